ascon_output_serializer: RTL and testbench



---
 rtl/ascon_pkg.sv | 30 +++
 rtl/ascon_output_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_ascon_output_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON output path.
// Contents:
//   ASCON_W_LEGAL(w) - macro, true when w is a supported output word width
//   ASCON_TAG_BITS   - tag length produced by the core
//   ser_state_e      - serializer FSM state encoding (IDLE/CT/TAG)
//   clog2()          - ceiling log2 for elaboration-time sizing
`ifndef ASCON_W_LEGAL
`define ASCON_W_LEGAL(w) (((w) == 8) || ((w) == 16) || ((w) == 32) || ((w) == 64))
`endif

package ascon_pkg;

    localparam int ASCON_TAG_BITS = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CT   = 2'd1,
        ST_TAG  = 2'd2
    } ser_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ascon_output_serializer.sv
// Captures the ASCON ciphertext and tag on the rising edge of enc_ready and
// streams them MSB-first as W-bit words over a valid/ready interface:
// ciphertext words (last one zero-padded at the LSBs) followed by tag words.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enc_ready         core result valid (level)
//   cipher_text, tag  core result, sampled on the enc_ready rising edge
//   out_data/out_valid/out_ready  word stream
//   out_is_tag        current word is a tag word
//   out_last          current word ends the frame
//   busy              a captured frame is still being transferred
//   frame_done        one-cycle pulse after the final word transfers
//   overrun           one-cycle pulse when a result arrives while busy (dropped)
module ascon_output_serializer
    import ascon_pkg::*;
#(
    parameter int Y_BITS   = 40,
    parameter int TAG_BITS = ASCON_TAG_BITS,
    parameter int W        = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enc_ready,
    input  logic [((Y_BITS > 0) ? Y_BITS : 1)-1:0]   cipher_text,
    input  logic [TAG_BITS-1:0]                      tag,
    output logic [W-1:0]                             out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_is_tag,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic                                     overrun
);

    localparam int YW       = (Y_BITS > 0) ? Y_BITS : 1;
    localparam int NCT      = (Y_BITS + W - 1) / W;
    localparam int NT       = TAG_BITS / W;
    localparam int NW       = NCT + NT;
    localparam int BUF_BITS = NW * W;
    localparam int CW       = clog2(NW + 1);

    localparam logic [CW-1:0] CT_LAST = CW'((NCT > 0) ? (NCT - 1) : 0);
    localparam logic [CW-1:0] NW_LAST = CW'(NW - 1);
    // Index of the word just before the final one; wraps (never matches) when NW==1.
    localparam logic [CW-1:0] NW_PEN  = CW'(NW - 2);

    generate
        if ((TAG_BITS % W) != 0) begin : g_bad_tag_w
            $error("ascon_output_serializer: TAG_BITS must be a multiple of W");
        end
        if (!(`ASCON_W_LEGAL(W))) begin : g_bad_w
            $error("ascon_output_serializer: W must be 8, 16, 32 or 64");
        end
    endgenerate

    ser_state_e           state_q, state_d;
    logic [BUF_BITS-1:0]  buf_q, buf_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic                 enc_ready_q;
    logic                 valid_q, valid_d;
    logic                 is_tag_q, is_tag_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic [BUF_BITS-1:0]  load_s;
    logic                 capture_s;
    logic                 xfer_s;

    assign capture_s = enc_ready & ~enc_ready_q;
    assign xfer_s    = valid_q & out_ready;

    // Assemble the frame image: ciphertext at the top, zero pad, tag at the bottom.
    always_comb begin
        load_s                 = '0;
        load_s[TAG_BITS-1:0]   = tag;
        if (Y_BITS > 0) begin
            load_s[BUF_BITS-1 -: YW] = cipher_text;
        end else begin
            load_s[TAG_BITS-1:0] = tag;
        end
    end

    // Next-state and output-register logic for the capture/stream FSM.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        wcnt_d    = wcnt_q;
        valid_d   = valid_q;
        is_tag_d  = is_tag_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    buf_d   = load_s;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    if (NCT > 0) begin
                        state_d  = ST_CT;
                        is_tag_d = 1'b0;
                        last_d   = 1'b0;
                    end else begin
                        state_d  = ST_TAG;
                        is_tag_d = 1'b1;
                        last_d   = (NW == 1) ? 1'b1 : 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CT: begin
                overrun_d = capture_s;
                if (xfer_s) begin
                    buf_d  = buf_q << W;
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == CT_LAST) begin
                        state_d  = ST_TAG;
                        is_tag_d = 1'b1;
                        last_d   = (wcnt_q == NW_PEN);
                    end else begin
                        state_d  = ST_CT;
                    end
                end else begin
                    state_d = ST_CT;
                end
            end
            ST_TAG: begin
                // A capture on the final-transfer cycle is still an overrun.
                overrun_d = capture_s;
                if (xfer_s) begin
                    buf_d  = buf_q << W;
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == NW_LAST) begin
                        state_d  = ST_IDLE;
                        valid_d  = 1'b0;
                        is_tag_d = 1'b0;
                        last_d   = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = ST_TAG;
                        last_d   = (wcnt_q == NW_PEN);
                    end
                end else begin
                    state_d = ST_TAG;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                buf_d    = '0;
                wcnt_d   = '0;
                valid_d  = 1'b0;
                is_tag_d = 1'b0;
                last_d   = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            wcnt_q      <= '0;
            enc_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            is_tag_q    <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            wcnt_q      <= wcnt_d;
            enc_ready_q <= enc_ready;
            valid_q     <= valid_d;
            is_tag_q    <= is_tag_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // out_data is the top word of the registered buffer: no path from out_ready.
    assign out_data   = buf_q[BUF_BITS-1 -: W];
    assign out_valid  = valid_q;
    assign out_is_tag = is_tag_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ascon_output_serializer.sv
// Directed bench for ascon_output_serializer with a word scoreboard.
// Instance 0: Y_BITS=40, instance 1: Y_BITS=0, instance 2: Y_BITS=64 (all W=32).
module tb_ascon_output_serializer;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic        is_tag;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    logic [2:0] enc_rdy;
    logic [2:0] ordy;
    logic [2:0] ov, ot, ol, bsy, fd, orun;
    logic [2:0][31:0] od;
    logic [39:0]  ct40;
    logic         ct0;
    logic [63:0]  ct64;
    logic [127:0] tag_in;

    exp_t sb_q[$];
    exp_t exp_e;
    exp_t obs_e;
    logic [2:0] last_prev;
    int checks;
    int errors;

    ascon_output_serializer #(.Y_BITS(40), .TAG_BITS(128), .W(32)) u40 (
        .clk(clk), .rst(rst), .enc_ready(enc_rdy[0]), .cipher_text(ct40), .tag(tag_in),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_is_tag(ot[0]),
        .out_last(ol[0]), .busy(bsy[0]), .frame_done(fd[0]), .overrun(orun[0])
    );

    ascon_output_serializer #(.Y_BITS(0), .TAG_BITS(128), .W(32)) u0 (
        .clk(clk), .rst(rst), .enc_ready(enc_rdy[1]), .cipher_text(ct0), .tag(tag_in),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_is_tag(ot[1]),
        .out_last(ol[1]), .busy(bsy[1]), .frame_done(fd[1]), .overrun(orun[1])
    );

    ascon_output_serializer #(.Y_BITS(64), .TAG_BITS(128), .W(32)) u64 (
        .clk(clk), .rst(rst), .enc_ready(enc_rdy[2]), .cipher_text(ct64), .tag(tag_in),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_is_tag(ot[2]),
        .out_last(ol[2]), .busy(bsy[2]), .frame_done(fd[2]), .overrun(orun[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] d, input logic t, input logic l);
        sb_q.push_back('{id: id, data: d, is_tag: t, last: l});
    endtask

    // Expected words of one frame for the given instance.
    task automatic push_frame(input logic [1:0] id);
        if (id == 2'd0) begin
            push(id, 32'h01234567, 1'b0, 1'b0);
            push(id, 32'h89000000, 1'b0, 1'b0);
        end else if (id == 2'd2) begin
            push(id, 32'hAABBCCDD, 1'b0, 1'b0);
            push(id, 32'h11223344, 1'b0, 1'b0);
        end
        push(id, 32'h00010203, 1'b1, 1'b0);
        push(id, 32'h04050607, 1'b1, 1'b0);
        push(id, 32'h08090A0B, 1'b1, 1'b0);
        push(id, 32'h0C0D0E0F, 1'b1, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        tick();
        tick();
    endtask

    // Scoreboard monitor: compares presented words and frame_done on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                last_prev[i] = 1'b0;
            end else begin
                checks++;
                assert (fd[i] === last_prev[i]) else begin
                    errors++;
                    $error("FAIL frame_done inst %0d observed %0b expected %0b", i, fd[i], last_prev[i]);
                end
                last_prev[i] = 1'b0;
                if (ov[i]) begin
                    checks++;
                    assert (sb_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_word inst %0d observed %h expected none", i, od[i]);
                    end
                    if (sb_q.size() != 0) begin
                        exp_e = sb_q[0];
                        obs_e = {2'(i), od[i], ot[i], ol[i]};
                        checks++;
                        assert (obs_e === exp_e) else begin
                            errors++;
                            $error("FAIL word inst %0d observed id=%0d data=%h tag=%0b last=%0b expected id=%0d data=%h tag=%0b last=%0b",
                                   i, obs_e.id, obs_e.data, obs_e.is_tag, obs_e.last,
                                   exp_e.id, exp_e.data, exp_e.is_tag, exp_e.last);
                        end
                        if (ordy[i]) begin
                            void'(sb_q.pop_front());
                            last_prev[i] = exp_e.last;
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        last_prev = 3'b000;
        rst       = 1'b1;
        enc_rdy   = 3'b000;
        ordy      = 3'b111;
        ct40      = 40'h0123456789;
        ct0       = 1'b0;
        ct64      = 64'hAABBCCDD11223344;
        tag_in    = 128'h000102030405060708090A0B0C0D0E0F;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("reset", {26'd0, ov[i], ot[i], ol[i], bsy[i], fd[i], orun[i], od[i]}, 64'd0);
        end

        // Basic frame, first-word latency
        push_frame(2'd0);
        enc_rdy[0] = 1'b1;
        tick();
        chk("latency_valid", {63'd0, ov[0]}, 64'd1);
        chk("latency_data", {32'd0, od[0]}, 64'h01234567);
        chk("busy_set", {63'd0, bsy[0]}, 64'd1);
        wait_drain("basic");
        chk("busy_clear", {63'd0, bsy[0]}, 64'd0);
        enc_rdy[0] = 1'b0;
        tick();

        // Backpressure on the second word
        push_frame(2'd0);
        enc_rdy[0] = 1'b1;
        tick();
        tick();
        ordy[0] = 1'b0;
        repeat (3) tick();
        chk("held_data", {32'd0, od[0]}, 64'h89000000);
        ordy[0] = 1'b1;
        wait_drain("backpressure");
        enc_rdy[0] = 1'b0;
        tick();

        // Overrun during the third word
        push_frame(2'd0);
        enc_rdy[0] = 1'b1;
        tick();
        enc_rdy[0] = 1'b0;
        tick();
        tick();
        enc_rdy[0] = 1'b1;
        tick();
        chk("overrun_pulse", {62'd0, orun[0], bsy[0]}, 64'd3);
        tick();
        chk("overrun_clear", {63'd0, orun[0]}, 64'd0);
        wait_drain("overrun");
        repeat (3) tick();
        chk("no_second_frame", {62'd0, ov[0], bsy[0]}, 64'd0);
        enc_rdy[0] = 1'b0;
        tick();

        // Reset while word 4 is presented; enc_ready stays high so release recaptures
        push_frame(2'd0);
        enc_rdy[0] = 1'b1;
        repeat (4) tick();
        chk("pre_reset_word", {32'd0, od[0]}, 64'h04050607);
        sb_q.delete();
        push_frame(2'd0);
        rst = 1'b1;
        tick();
        chk("reset_abort", {61'd0, ov[0], bsy[0], fd[0]}, 64'd0);
        rst = 1'b0;
        wait_drain("after_reset");
        enc_rdy[0] = 1'b0;
        tick();

        // Empty ciphertext: tag words only
        push_frame(2'd1);
        enc_rdy[1] = 1'b1;
        tick();
        chk("y0_first", {31'd0, ot[1], od[1]}, {31'd0, 1'b1, 32'h00010203});
        wait_drain("y0");
        enc_rdy[1] = 1'b0;

        // 64-bit ciphertext: no pad word
        push_frame(2'd2);
        enc_rdy[2] = 1'b1;
        tick();
        wait_drain("y64");
        chk("y64_idle", {62'd0, ov[2], bsy[2]}, 64'd0);
        enc_rdy[2] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
